// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with valid/ready output
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t               state, state_nxt;
    logic                 rx_meta, rxs;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 stop_err;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_end;
    logic                 frame_done;
    logic                 frame_err_nxt;
    logic                 load_ok;
    logic                 accept;

    assign bit_end       = (cnt == LAST_CNT);
    assign frame_err_nxt = stop_err | ~rxs;
    assign load_ok       = ~rx_valid | rx_ready;
    assign accept        = rx_valid & rx_ready;
    assign rx_busy       = (state != S_IDLE);

    // Two-flop synchroniser; resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= data_in;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            S_IDLE:  if (!rxs) state_nxt = S_START;
            S_START: if (cnt == MID_CNT) state_nxt = rxs ? S_IDLE : S_DATA;
            S_DATA: begin
                if (bit_end && bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (bit_end) state_nxt = S_STOP;
`endif
            S_STOP: begin
                if (bit_end && stop_idx == LAST_STOP) begin
                    frame_done = 1'b1;
                    state_nxt  = frame_err_nxt ? S_BREAK : S_IDLE;
                end
            end
            S_BREAK: if (rxs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit-period counter restarts on every state change so START->DATA re-aligns to mid-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            stop_err <= 1'b0;
            shreg    <= '0;
        end else begin
            if (state_nxt != state || state == S_IDLE || state == S_BREAK || bit_end)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == S_START) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                stop_err <= 1'b0;
            end
            if (state == S_DATA && bit_end) begin
                shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == S_STOP && bit_end) begin
                stop_idx <= stop_idx + 1'b1;
                if (!rxs) stop_err <= 1'b1;
            end
        end
    end

    // Holding register: load wins over accept, a full unaccepted register drops the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (frame_done) begin
                if (load_ok) begin
                    rx_data      <= shreg;
                    rx_valid     <= 1'b1;
                    rx_frame_err <= frame_err_nxt;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (accept) begin
                rx_valid     <= 1'b0;
                rx_frame_err <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit       <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            if (state == S_PARITY && bit_end) par_bit <= rxs;
            if (frame_done) begin
                if (load_ok) rx_parity_err <= (^{shreg, par_bit}) ^ PAR_ODD;
            end else if (accept) begin
                rx_parity_err <= 1'b0;
            end
        end
    end
`else
    logic unused_par_cfg;
    assign unused_par_cfg = (PARITY_ODD != 0);
    assign rx_parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int CPB  = 8;
    localparam int PODD = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_in = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_busy;

    uart_rx_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PODD)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
        .rx_overrun(rx_overrun), .rx_busy(rx_busy)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_cmp;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         frames_seen = 0;
    int         ovr_cycles = 0;
    int         valid_rise_cyc = -1;
    logic       prev_valid = 1'b0;
    logic       hold_prev = 1'b0;
    logic [7:0] held_d;
    logic       held_fe, held_pe;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Parity error from the frame's ones-count, independent of how the DUT folds bits
    function automatic logic model_perr(input logic [7:0] d, input logic p);
`ifdef UART_RX_PARITY_EN
        return (($countones({d, p}) % 2) != PODD);
`else
        return (d[0] & 1'b0) | (p & 1'b0);
`endif
    endfunction

    task automatic bit_out(input logic b);
        data_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic bad_par, input logic expect_it);
        exp_t e;
        logic pbit;
        pbit = (($countones(d) % 2) == 1) ^ (PODD != 0) ^ bad_par;
        if (expect_it) begin
            e.d  = d;
            e.fe = !stop_v;
            e.pe = model_perr(d, pbit);
            exp_q.push_back(e);
        end
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_out(pbit);
`endif
        bit_out(stop_v);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, rx_valid, 1'b0);
        check({tag, "_data"}, rx_data, 8'h00);
        check({tag, "_ferr"}, rx_frame_err, 1'b0);
        check({tag, "_perr"}, rx_parity_err, 1'b0);
        check({tag, "_ovr"}, rx_overrun, 1'b0);
        check({tag, "_busy"}, rx_busy, 1'b0);
    endtask

    // Per-cycle scoreboard on the opposite clock edge
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
            if (hold_prev && rx_valid) begin
                check("hold_data", rx_data, held_d);
                check("hold_ferr", rx_frame_err, held_fe);
                check("hold_perr", rx_parity_err, held_pe);
            end
            if (!rx_valid) check("flags_idle", {rx_frame_err, rx_parity_err}, 2'b00);
            if (rx_valid && rx_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame: actual=0x%0h required=none", rx_data);
                end else begin
                    e_cmp = exp_q.pop_front();
                    frames_seen++;
                    check("frame_data", rx_data, e_cmp.d);
                    check("frame_ferr", rx_frame_err, e_cmp.fe);
                    check("frame_perr", rx_parity_err, e_cmp.pe);
                end
            end
            if (rx_overrun) ovr_cycles++;
        end
        prev_valid = rx_valid;
        hold_prev  = rx_valid && !rx_ready;
        held_d     = rx_data;
        held_fe    = rx_frame_err;
        held_pe    = rx_parity_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int lat;
        logic busy_seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;

        // 1: plain 8N1 frame and its latency from the start edge
        t0 = cyc;
        send_frame(8'h3F, 1'b1, 1'b0, 1'b1);
        wait_drain("t1_drain");
        lat = valid_rise_cyc - t0;
        check("t1_latency_in_window", (lat >= 76 && lat <= 82), 1'b1);
        check("t1_data_kept", rx_data, 8'h3F);
        check("t1_no_overrun", ovr_cycles, 0);

        // 2: 2-clk glitch is rejected
        data_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        data_in   = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rx_busy) busy_seen = 1'b1;
        end
        check("t2_busy_seen", busy_seen, 1'b1);
        check("t2_busy_cleared", rx_busy, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("t2_no_frame", frames_seen, 1);

        // 3: framing error, long break, then recovery
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        repeat (20 * CPB) @(posedge clk);
        #1;
        check("t3_break_frames", frames_seen, 2);
        data_in = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        send_frame(8'h12, 1'b1, 1'b0, 1'b1);
        wait_drain("t3_drain");

        // 4: overrun with consumer stalled
        rx_ready = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t4_valid_held", rx_valid, 1'b1);
        check("t4_data_held", rx_data, 8'hA5);
        check("t4_ovr_one_cycle", ovr_cycles, 1);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_valid_dropped", rx_valid, 1'b0);
        wait_drain("t4_drain");

`ifdef UART_RX_PARITY_EN
        // 5: even parity good and bad
        check("t5_model_pin_bad", model_perr(8'hAA, 1'b1), 1'b1);
        check("t5_model_pin_good", model_perr(8'hAA, 1'b0), 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0, 1'b1);
        wait_drain("t5_good_drain");
        send_frame(8'hAA, 1'b1, 1'b1, 1'b1);
        wait_drain("t5_bad_drain");
`endif

        // 6: reset in the middle of data bit 4 of 0xF0
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b0);
        data_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("t6_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6 * CPB) @(posedge clk);
        #1;
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        wait_drain("t6_drain");
        check("t6_data_kept", rx_data, 8'h81);

`ifdef UART_RX_PARITY_EN
        check("total_frames", frames_seen, 7);
`else
        check("total_frames", frames_seen, 5);
`endif
        check("total_overrun_cycles", ovr_cycles, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
